// File: rtl/shift_unit.sv
// Multi-cycle variable shifter: SLL/SRL/SRA/ROTR of a WIDTH-bit operand,
// advancing STEP bit positions per clock under a start/busy/done handshake.
module shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out
);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  localparam logic [SHAMT_W:0] STEP_EXT = (SHAMT_W+1)'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   data_reg,  data_next;
  logic [SHAMT_W-1:0] rem_reg,   rem_next;
  logic [1:0]         op_reg,    op_next;
  logic               sign_reg,  sign_next;
  logic [WIDTH-1:0]   out_reg,   out_next;

  logic [SHAMT_W-1:0] k;
  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   cand [STEP+1];

  // The final step may be partial, so the per-cycle amount is min(STEP, rem).
  always_comb begin
    if ({1'b0, rem_reg} < STEP_EXT) begin
      k = rem_reg;
    end else begin
      k = STEP_EXT[SHAMT_W-1:0];
    end
  end

  // One candidate result per possible amount 0..STEP; k selects among them.
  generate
    for (genvar gi = 0; gi <= STEP; gi++) begin : g_cand
      logic [2*WIDTH-1:0] sra_wide;
      logic [2*WIDTH-1:0] rot_wide;
      assign sra_wide = {{WIDTH{sign_reg}}, data_reg} >> gi;
      assign rot_wide = {data_reg, data_reg} >> gi;
      always_comb begin
        unique case (op_reg)
          OP_SLL:  cand[gi] = data_reg << gi;
          OP_SRL:  cand[gi] = data_reg >> gi;
          OP_SRA:  cand[gi] = sra_wide[WIDTH-1:0];
          OP_ROTR: cand[gi] = rot_wide[WIDTH-1:0];
          default: cand[gi] = data_reg;
        endcase
      end
    end
  endgenerate

  always_comb begin
    shifted = data_reg;
    for (int i = 0; i <= STEP; i++) begin
      if (int'(k) == i) begin
        shifted = cand[i];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    rem_next   = rem_reg;
    op_next    = op_reg;
    sign_next  = sign_reg;
    out_next   = out_reg;
    unique case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          data_next = in;
          rem_next  = shamt;
          op_next   = op;
          sign_next = in[WIDTH-1];
          if (shamt == '0) begin
            out_next   = in;
            state_next = DONE;
          end else begin
            state_next = SHIFT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        data_next = shifted;
        rem_next  = rem_reg - k;
        if (rem_reg == k) begin
          out_next   = shifted;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      rem_reg   <= '0;
      op_reg    <= '0;
      sign_reg  <= 1'b0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      rem_reg   <= rem_next;
      op_reg    <= op_next;
      sign_reg  <= sign_next;
      out_reg   <= out_next;
    end
  end

  assign busy = (state_reg == SHIFT);
  assign done = (state_reg == DONE);
  assign out  = out_reg;

endmodule
